// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants and types for the RV32M/RV64M multiply/divide unit.
//   - funct3 encodings of the M-extension ops
//   - funct7 value that routes an OP instruction to this unit
//   - FSM state type and operand-signedness helpers
package muldiv_pkg;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] FUNCT3_MUL    = 3'b000;
    localparam logic [2:0] FUNCT3_MULH   = 3'b001;
    localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
    localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
    localparam logic [2:0] FUNCT3_DIV    = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
    localparam logic [2:0] FUNCT3_REM    = 3'b110;
    localparam logic [2:0] FUNCT3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIXUP,
        ST_DONE
    } muldiv_state_t;

    function automatic logic rs1_is_signed(input logic [2:0] f);
        return (f == FUNCT3_MULH) || (f == FUNCT3_MULHSU) ||
               (f == FUNCT3_DIV)  || (f == FUNCT3_REM);
    endfunction

    function automatic logic rs2_is_signed(input logic [2:0] f);
        return (f == FUNCT3_MULH) || (f == FUNCT3_DIV) || (f == FUNCT3_REM);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between pipeline control and muldiv_unit.
//   request : in_valid, in_ready, funct3, rs1_value, rs2_value, in_tag
//   response: out_valid, out_ready, aluout, out_tag
//   master = pipeline side, slave = muldiv_unit side.
interface muldiv_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       funct3;
    logic [XLEN-1:0]  rs1_value;
    logic [XLEN-1:0]  rs2_value;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  aluout;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, funct3, rs1_value, rs2_value, in_tag, out_ready,
        input  in_ready, out_valid, aluout, out_tag
    );

    modport slave (
        input  in_valid, funct3, rs1_value, rs2_value, in_tag, out_ready,
        output in_ready, out_valid, aluout, out_tag
    );
endinterface

// File: rtl/muldiv_core.sv
// muldiv_core: iterative datapath of the multiply/divide unit.
//   start  : load operand magnitudes/sign flags; load special-case result directly
//   step   : one shift-add (multiply) or restoring shift-subtract (divide) iteration
//   fixup  : sign correction and result selection into result
//   special: combinational flag, current request resolves without iterating
module muldiv_core
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            step,
    input  logic            fixup,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            special,
    output logic [XLEN-1:0] result
);

    // acc holds {high, low}: multiply = {partial product, multiplier},
    // divide = {remainder, dividend shifting into quotient}.
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [2:0]        op_q, op_d;
    logic              neg1_q, neg1_d, neg2_q, neg2_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              neg1, neg2, div_by_zero, overflow;
    logic [XLEN-1:0]   a_mag, b_mag, special_val;
    logic [XLEN:0]     sum, shifted, diff;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem;

    always_comb begin
        acc_d       = acc_q;
        opnd_d      = opnd_q;
        op_d        = op_q;
        neg1_d      = neg1_q;
        neg2_d      = neg2_q;
        result_d    = result_q;
        neg1        = rs1_is_signed(funct3) & rs1[XLEN-1];
        neg2        = rs2_is_signed(funct3) & rs2[XLEN-1];
        a_mag       = neg1 ? -rs1 : rs1;
        b_mag       = neg2 ? -rs2 : rs2;
        div_by_zero = funct3[2] && (rs2 == '0);
        overflow    = ((funct3 == FUNCT3_DIV) || (funct3 == FUNCT3_REM)) &&
                      (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
        special     = div_by_zero || overflow;
        if (div_by_zero) special_val = funct3[1] ? rs1 : '1;
        else             special_val = funct3[1] ? '0 : rs1;

        sum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        shifted = acc_q[2*XLEN-1:XLEN-1];
        // Partial remainder is always below the divisor, so diff[XLEN] is the borrow.
        diff    = shifted - {1'b0, opnd_q};
        prod    = (neg1_q ^ neg2_q) ? -acc_q : acc_q;
        quo     = (neg1_q ^ neg2_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem     = neg1_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

        if (start) begin
            op_d   = funct3;
            neg1_d = neg1;
            neg2_d = neg2;
            if (funct3[2]) begin
                opnd_d = b_mag;
                acc_d  = {{XLEN{1'b0}}, a_mag};
            end else begin
                opnd_d = a_mag;
                acc_d  = {{XLEN{1'b0}}, b_mag};
            end
            if (special) result_d = special_val;
        end else if (step) begin
            if (op_q[2])
                acc_d = {diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0],
                         acc_q[XLEN-2:0], ~diff[XLEN]};
            else
                acc_d = {sum, acc_q[XLEN-1:1]};
        end else if (fixup) begin
            case (op_q)
                FUNCT3_MUL:                result_d = prod[XLEN-1:0];
                FUNCT3_DIV, FUNCT3_DIVU:   result_d = quo;
                FUNCT3_REM, FUNCT3_REMU:   result_d = rem;
                default:                   result_d = prod[2*XLEN-1:XLEN];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            opnd_q   <= '0;
            op_q     <= '0;
            neg1_q   <= 1'b0;
            neg2_q   <= 1'b0;
            result_q <= '0;
        end else begin
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            op_q     <= op_d;
            neg1_q   <= neg1_d;
            neg2_q   <= neg2_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M/RV64M multiply/divide unit.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : abandon the in-flight op, return to IDLE
//   busy       : unit holds an op (state != IDLE)
//   bus        : request/response handshake (muldiv_if.slave)
//
// state    | meaning
// ---------+------------------------------------------------------
// IDLE     | waiting for a request, in_ready high
// CALC     | XLEN iterations of shift-add / shift-subtract
// FIXUP    | sign correction and result selection
// DONE     | out_valid high, result held until out_ready
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     flush,
    output logic     busy,
    muldiv_if.slave  bus
);

    localparam int CNT_W = $clog2(XLEN);

    muldiv_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             in_ready_q, in_ready_d;
    logic             accept, start, step, fixup, special;
    logic [XLEN-1:0]  result;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tag_d   = tag_q;
        start   = 1'b0;
        step    = 1'b0;
        fixup   = 1'b0;
        accept  = bus.in_valid && in_ready_q && !flush;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    start   = 1'b1;
                    tag_d   = bus.in_tag;
                    cnt_d   = '0;
                    state_d = special ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                step  = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(XLEN-1)) state_d = ST_FIXUP;
            end
            ST_FIXUP: begin
                fixup   = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (bus.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
        // Registered so in_ready reads 0 during reset and has no path from out_ready.
        in_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            tag_q      <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tag_q      <= tag_d;
            in_ready_q <= in_ready_d;
        end
    end

    muldiv_core #(.XLEN(XLEN)) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .step    (step),
        .fixup   (fixup),
        .funct3  (bus.funct3),
        .rs1     (bus.rs1_value),
        .rs2     (bus.rs2_value),
        .special (special),
        .result  (result)
    );

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.aluout    = result;
    assign bus.out_tag   = tag_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised multi-cycle RV32M/RV64M multiply/divide unit. It sits beside the single-cycle execute ALU and takes every OP-opcode instruction with funct7 = 0000001. The unit computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU with an iterative one-bit-per-cycle datapath behind valid/ready handshakes. Pipeline control uses it to retire long-latency ops without stalling the ALU's combinational path.

## Interface
Parameters:
- XLEN, 32, operand/result width (32 or 64)
- TAG_W, 5, width of the destination-register tag carried with each op

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  kill in-flight op (branch mispredict/trap)
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept; high only in IDLE
- funct3  in  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1_value  in  XLEN  operand A (dividend/multiplicand)
- rs2_value  in  XLEN  operand B (divisor/multiplier)
- in_tag  in  TAG_W  rd index, returned unchanged
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- aluout  out  XLEN  result
- out_tag  out  TAG_W  tag of the result
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, CALC, FIXUP, DONE.
- IDLE:
  - On in_valid && in_ready && !flush, latch operands, funct3 and tag.
  - Record sign flags: rs1 is signed for MULH/MULHSU/DIV/REM; rs2 is signed for MULH/DIV/REM.
  - Store absolute values; clear the counter.
- Special cases, decided at accept, go IDLE -> DONE directly:
  - DIV/DIVU with rs2 = 0: quotient = all ones.
  - REM/REMU with rs2 = 0: remainder = rs1.
  - DIV with rs1 = most-negative and rs2 = -1: result = rs1.
  - REM with rs1 = most-negative and rs2 = -1: result = 0.
- CALC, exactly XLEN cycles, counter 0..XLEN-1:
  - Multiply: shift-add into a 2*XLEN accumulator.
  - Divide: restoring shift-subtract producing quotient and remainder.
- FIXUP, 1 cycle, sign correction:
  - Product: negated if the sign flags differ.
  - Quotient: negated if the dividend and divisor signs differ.
  - Remainder: takes the dividend sign.
  - Result selection: MUL takes the low XLEN bits; MULH/MULHSU/MULHU take the high XLEN bits.
- DONE:
  - out_valid = 1; aluout and out_tag stay stable until out_valid && out_ready.
  - On that handshake, go to IDLE.
- flush, any state: next state IDLE, out_valid deasserted next cycle, result discarded. flush in the same cycle as in_valid means no accept.
- All arithmetic is modulo 2^XLEN; unsigned compare in the divider uses XLEN+1-bit subtraction.

## Timing
- Reset value of every output is 0 (in_ready returns 1 on the first edge after reset deassertion, since state = IDLE).
- Latency, counted from the accept edge to the first cycle with out_valid high:
  - Normal op: XLEN+2 cycles (34 for XLEN=32).
  - Special case: 1 cycle.
- Throughput: one op per XLEN+3 cycles minimum. No accept in DONE, even if out_ready is high.
- in_ready is a registered-state decode with no combinational path from out_ready.
- Reset asserted mid-operation: the FSM goes to IDLE immediately and asynchronously. Outputs clear with no result produced.

## Structure
- muldiv_pkg holds:
  - funct3 localparams (FUNCT3_MUL .. FUNCT3_REMU)
  - M-extension funct7 constant 7'b0000001
  - state enum type muldiv_state_t
- One natural sub-module, muldiv_core: the datapath holding the accumulator, shift/subtract and negate logic, controlled by start/step/fixup strobes. The FSM, handshake and tag register stay in muldiv_unit.

## Test plan
All scenarios use XLEN=32.
- MUL 7 x 0xFFFFFFFD -> aluout 0xFFFFFFEB, out_valid exactly 34 cycles after accept, out_tag echoes in_tag=5'd9.
- 0xFFFFFFFF x 0xFFFFFFFF under each high-half op:
  - MULHU -> 0xFFFFFFFE
  - MULH -> 0x00000000
  - MULHSU -> 0xFFFFFFFF
- Division:
  - DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF.
  - DIVU 100 / 7 -> 14; REMU -> 2.
- Special cases, each with out_valid 1 cycle after accept:
  - DIV 5 / 0 -> 0xFFFFFFFF; REM 5 / 0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
- Backpressure: out_ready held low 5 cycles in DONE -> aluout/out_tag stable, in_ready 0. A back-to-back op is accepted only in the cycle after the handshake.
- Kill and reset:
  - flush on CALC cycle 10 -> no out_valid ever for that op; in_ready 1 next cycle; the next op returns a correct result.
  - rst_n pulsed low mid-CALC -> all outputs 0 asynchronously.
